// File: rtl/mem_line_arbiter_pkg.sv
// Shared types and defaults for the line-memory arbiter: state encoding,
// width defaults and the saturating increment used by the perf counters.
package mem_line_arbiter_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int LINE_W_DEF = 64;
  localparam int PERF_W     = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WB     = 3'd1,
    D_FILL = 3'd2,
    I_FILL = 3'd3,
    RESP   = 3'd4
  } arb_state_e;

  // Holds at all-ones instead of wrapping.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (v == {PERF_W{1'b1}}) ? v : v + PERF_W'(1);
  endfunction

endpackage

// File: rtl/mem_line_arbiter_if.sv
// Unified line-memory bus: the arbiter drives strobes/address/write data,
// the memory returns read data together with a one-cycle completion pulse.
interface mem_line_arbiter_if
  import mem_line_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
);

  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_rdy;

  modport master (
    output mem_re, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_rdy
  );

  modport slave (
    input  mem_re, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_rdy
  );

endinterface

// File: rtl/mem_line_arbiter_perf_ctr.sv
// Saturating event counter (mem_arb_perf_ctr), instanced by the arbiter when
// MEM_ARB_PERF_EN is defined.
module mem_arb_perf_ctr
  import mem_line_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [PERF_W-1:0] cnt
);

  logic [PERF_W-1:0] cnt_q;
  logic [PERF_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc) cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mem_line_arbiter.sv
// Single-port line-memory arbiter for I-fills, D-fills and dirty writebacks.
// Optional MEM_ARB_PERF_EN adds saturating op/stall counters as outputs.
module mem_line_arbiter
  import mem_line_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                d_req,
  input  logic                d_dirty,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [ADDR_W-1:0]   d_victim_addr,
  input  logic [LINE_W-1:0]   d_victim_data,
  mem_line_arbiter_if.master  mem,
  output logic [LINE_W-1:0]   fill_data,
  output logic                i_fill_vld,
  output logic                d_fill_vld,
  output logic                busy
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [PERF_W-1:0]   perf_i_fills,
  output logic [PERF_W-1:0]   perf_d_fills,
  output logic [PERF_W-1:0]   perf_wbs,
  output logic [PERF_W-1:0]   perf_stall_cyc
`endif
);

  arb_state_e        state_q, state_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [LINE_W-1:0] fill_data_q, fill_data_d;
  logic              i_fill_vld_q, i_fill_vld_d;
  logic              d_fill_vld_q, d_fill_vld_d;
  logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;
  logic              tgt_d_q, tgt_d_d;
  logic              hold_q, hold_d;

  // Strobes and addresses are computed for the next state so they come out
  // of flops; a grant in IDLE shows its strobe on the following cycle.
  always_comb begin
    state_d      = state_q;
    mem_re_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    fill_data_d  = fill_data_q;
    i_fill_vld_d = 1'b0;
    d_fill_vld_d = 1'b0;
    miss_addr_d  = miss_addr_q;
    tgt_d_d      = tgt_d_q;
    hold_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The cycle right after RESP still sees the just-served request.
        if (!hold_q) begin
          if (d_req) begin
            miss_addr_d = d_addr;
            tgt_d_d     = 1'b1;
            if (d_dirty) begin
              state_d     = WB;
              mem_we_d    = 1'b1;
              mem_addr_d  = d_victim_addr;
              mem_wdata_d = d_victim_data;
            end else begin
              state_d    = D_FILL;
              mem_re_d   = 1'b1;
              mem_addr_d = d_addr;
            end
          end else if (i_req) begin
            miss_addr_d = i_addr;
            tgt_d_d     = 1'b0;
            state_d     = I_FILL;
            mem_re_d    = 1'b1;
            mem_addr_d  = i_addr;
          end
        end
      end

      WB: begin
        if (mem.mem_rdy) begin
          state_d    = D_FILL;
          mem_re_d   = 1'b1;
          mem_addr_d = miss_addr_q;
        end else begin
          mem_we_d = 1'b1;
        end
      end

      D_FILL, I_FILL: begin
        if (mem.mem_rdy) begin
          state_d      = RESP;
          fill_data_d  = mem.mem_rdata;
          d_fill_vld_d = tgt_d_q;
          i_fill_vld_d = !tgt_d_q;
        end else begin
          mem_re_d = 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
        hold_d  = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      fill_data_q  <= '0;
      i_fill_vld_q <= 1'b0;
      d_fill_vld_q <= 1'b0;
      miss_addr_q  <= '0;
      tgt_d_q      <= 1'b0;
      hold_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      fill_data_q  <= fill_data_d;
      i_fill_vld_q <= i_fill_vld_d;
      d_fill_vld_q <= d_fill_vld_d;
      miss_addr_q  <= miss_addr_d;
      tgt_d_q      <= tgt_d_d;
      hold_q       <= hold_d;
    end
  end

  assign mem.mem_re    = mem_re_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign fill_data     = fill_data_q;
  assign i_fill_vld    = i_fill_vld_q;
  assign d_fill_vld    = d_fill_vld_q;
  assign busy          = (state_q != IDLE);

`ifdef MEM_ARB_PERF_EN
  logic wb_done;
  assign wb_done = (state_q == WB) && mem.mem_rdy;

  mem_arb_perf_ctr u_ctr_i_fills (.clk(clk), .rst(rst), .inc(i_fill_vld_q), .cnt(perf_i_fills));
  mem_arb_perf_ctr u_ctr_d_fills (.clk(clk), .rst(rst), .inc(d_fill_vld_q), .cnt(perf_d_fills));
  mem_arb_perf_ctr u_ctr_wbs     (.clk(clk), .rst(rst), .inc(wb_done),      .cnt(perf_wbs));
  mem_arb_perf_ctr u_ctr_stall   (.clk(clk), .rst(rst), .inc(busy),         .cnt(perf_stall_cyc));
`endif

endmodule

// File: doc/mem_line_arbiter.md
Name: mem_line_arbiter

Overview:
Arbitrates I-cache line fills, D-cache line fills and dirty-victim writebacks onto the single unified multi-cycle line memory. It sits directly upstream of the pipeline's cache controller and resolves the misses that hold i_rdy/d_rdy low. It serves one transaction at a time. A dirty D-miss is sequenced as writeback then fill.

Parameters:
ADDR_W, 14, line address width (16-bit word address, 4 words per line)
LINE_W, 64, line data width in bits

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
i_req  in  1  I-cache miss, level; held until i_fill_vld
i_addr  in  ADDR_W  I-cache miss line address
d_req  in  1  D-cache miss, level; held until d_fill_vld
d_dirty  in  1  victim line is dirty; sampled at grant
d_addr  in  ADDR_W  D-cache miss line address
d_victim_addr  in  ADDR_W  line address of dirty victim
d_victim_data  in  LINE_W  victim line data
mem_re  out  1  memory read strobe
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  memory line address
mem_wdata  out  LINE_W  memory write data
mem_rdata  in  LINE_W  memory read data; valid with mem_rdy
mem_rdy  in  1  memory op complete, one-cycle pulse
fill_data  out  LINE_W  registered fill line
i_fill_vld  out  1  one-cycle pulse: fill_data is for I-cache
d_fill_vld  out  1  one-cycle pulse: fill_data is for D-cache
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - mem_re, mem_we, i_fill_vld, d_fill_vld and busy are 0.
  - mem_addr, mem_wdata and fill_data are 0.
  - Any in-flight memory operation is abandoned. A late mem_rdy after reset is ignored.
- States are IDLE, WB, D_FILL, I_FILL and RESP.
- IDLE arbitration:
  - d_req has fixed priority over i_req. The D-stage instruction is older.
  - d_req with d_dirty=1 goes to WB.
  - d_req with d_dirty=0 goes to D_FILL.
  - Otherwise i_req goes to I_FILL.
  - Otherwise the block stays in IDLE.
- Grant capture: at grant, d_addr/i_addr, d_victim_addr and d_victim_data are latched. Requesters may change them afterwards without effect.
- Memory strobes are registered outputs.
  - mem_we=1 only in WB.
  - mem_re=1 only in D_FILL or I_FILL.
  - Strobe and mem_addr are held stable until mem_rdy.
- WB: mem_addr=victim address and mem_wdata=victim data. On mem_rdy, go to D_FILL. mem_we drops and mem_re rises in the same cycle.
- D_FILL / I_FILL: mem_addr=latched miss address. On mem_rdy:
  - capture mem_rdata into fill_data;
  - set the target flag;
  - go to RESP.
- RESP (one cycle):
  - pulse i_fill_vld or d_fill_vld;
  - strobes are 0;
  - next state is IDLE.
  - Requesters drop req in the cycle after the pulse. The IDLE that follows RESP must ignore req for that one cycle (no re-grant of a stale request).
- mem_rdy is ignored in IDLE and RESP.
- Latency:
  - req seen in IDLE at cycle 0; strobe high in cycle 1.
  - Fill pulse occurs the cycle after mem_rdy.
  - Minimum clean fill is 3 cycles plus memory latency.
- No preemption. A d_req arriving during I_FILL waits for I_FILL to complete.
- No starvation. i_req waits at most one D transaction, because d_req cannot re-assert until the pipeline advances.
- If i_addr equals a victim being written back, ordering is strict: WB completes before any fill issues, so the I-fill sees the new data.

Optional Feature:
MEM_ARB_PERF_EN.
- Defined:
  - adds three 16-bit saturating counters: perf_i_fills, perf_d_fills and perf_wbs. Each increments once per completed op.
  - adds perf_stall_cyc, a 16-bit saturating count of cycles with busy=1.
  - All four are output ports, cleared by rst.
- Undefined: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - the state encoding enum (IDLE, WB, D_FILL, I_FILL, RESP);
  - the LINE_W/ADDR_W defaults;
  - the perf counter width.
- Natural sub-module: mem_arb_perf_ctr, a saturating counter instanced four times under MEM_ARB_PERF_EN.

Test Plan:
- Clean D-miss: d_req=1, d_dirty=0, d_addr=0x0123. Memory returns mem_rdy 4 cycles after mem_re with rdata=0xDEADBEEF_CAFEF00D. Required: mem_re=1 with mem_addr=0x0123, then d_fill_vld 1 cycle after mem_rdy with fill_data=0xDEADBEEF_CAFEF00D, and i_fill_vld=0 throughout.
- Dirty D-miss: d_dirty=1, victim 0x0040 with data 0x1111_2222_3333_4444, d_addr=0x0080. Required: mem_we at 0x0040 with that wdata; after mem_rdy, mem_re at 0x0080 with no gap cycle; then d_fill_vld.
- Simultaneous request: i_req (0x0005) and d_req (0x0200) both rise in the same cycle. Required: D is served first and d_fill_vld fires; I_FILL at 0x0005 follows; i_fill_vld comes last.
- No preemption: d_req rises 2 cycles into I_FILL. Required: mem_addr stays at the I address until mem_rdy; i_fill_vld fires; D is granted afterwards.
- Reset mid-WB: assert rst during WB before mem_rdy, then pulse a stray mem_rdy after release. Required: all outputs are 0 immediately (asynchronously), the state is IDLE, and the stray mem_rdy causes no fill pulse.
- With MEM_ARB_PERF_EN: run 2 I-fills and 1 dirty D-miss. Required: perf_i_fills=2, perf_d_fills=1, perf_wbs=1, and perf_stall_cyc equals the counted busy cycles.
